// File: rtl/bbox_scan.sv
// Pipelined bounding-box scanner for bottom-up BMP pixel data in byte-wide memory.
// Optional feature: define BBOX_PIXEL_COUNT_EN to add the pixel_count output.
module bbox_scan #(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int CHANNELS   = 3,
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        threshold,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    input  logic [7:0]        rddata,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [15:0]       xMin,
    output logic [15:0]       xMax,
    output logic [15:0]       yMin,
    output logic [15:0]       yMax
`ifdef BBOX_PIXEL_COUNT_EN
    ,
    output logic [31:0]       pixel_count
`endif
);

    localparam longint N_TOTAL   = longint'(WIDTH) * longint'(HEIGHT) * longint'(CHANNELS);
    localparam int     ROW_BYTES = WIDTH * CHANNELS;
    localparam int     STRIDE    = ((ROW_BYTES + 3) / 4) * 4;

    localparam logic [ADDR_W-1:0] FIRST_OFF = ADDR_W'(longint'(HEIGHT - 1) * longint'(STRIDE));
    // Step from the last byte of a row back to the first byte of the row above it in the image.
    localparam logic [ADDR_W-1:0] ROW_BACK  = ADDR_W'(STRIDE + ROW_BYTES - 1);
    localparam logic [15:0]       X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0]       Y_LAST    = 16'(HEIGHT - 1);
    localparam logic [1:0]        C_LAST    = 2'(CHANNELS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 65535 || HEIGHT < 1 || HEIGHT > 65535 ||
            CHANNELS < 1 || CHANNELS > 4 || RD_LATENCY < 1 || RD_LATENCY > 8 ||
            ADDR_W < 1 || ADDR_W > 64) begin : g_bad_param
            $error("bbox_scan: parameter out of range");
        end
        if (N_TOTAL >= 64'sh1_0000_0000) begin : g_too_big
            $error("bbox_scan: WIDTH*HEIGHT*CHANNELS must be below 2^32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] x;
        logic [15:0] y;
        logic        last_chan;
        logic        last_all;
    } tag_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              empty_q, empty_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [1:0]        c_q, c_d;
    logic [7:0]        thr_q, thr_d;
    tag_t              pipe_q [RD_LATENCY];
    tag_t              pipe_d [RD_LATENCY];
    logic              pix_dark_q, pix_dark_d;
    logic              found_q, found_d;
    logic              fin_q, fin_d;
    logic [15:0]       run_x0_q, run_x0_d, run_x1_q, run_x1_d;
    logic [15:0]       run_y0_q, run_y0_d, run_y1_q, run_y1_d;
    logic [15:0]       x_min_q, x_min_d, x_max_q, x_max_d;
    logic [15:0]       y_min_q, y_min_d, y_max_q, y_max_d;
`ifdef BBOX_PIXEL_COUNT_EN
    logic [31:0]       run_cnt_q, run_cnt_d, cnt_q, cnt_d;
`endif

    tag_t ret_s;
    logic last_issue_s;
    logic px_dark_s;
    logic upd_s;

    // Next-state logic: issue-side address walk, tagged return aggregation and scan control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_en_d    = rd_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        empty_d    = empty_q;
        x_d        = x_q;
        y_d        = y_q;
        c_d        = c_q;
        thr_d      = thr_q;
        x_min_d    = x_min_q;
        x_max_d    = x_max_q;
        y_min_d    = y_min_q;
        y_max_d    = y_max_q;

        last_issue_s = (c_q == C_LAST) && (x_q == X_LAST) && (y_q == Y_LAST);
        pipe_d[0] = '{valid: rd_en_q, x: x_q, y: y_q,
                      last_chan: (c_q == C_LAST), last_all: last_issue_s};
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // The oldest tag lines up with the byte memory is returning this cycle.
        ret_s     = pipe_q[RD_LATENCY-1];
        px_dark_s = pix_dark_q | (rddata < thr_q);
        upd_s     = ret_s.valid & ret_s.last_chan & px_dark_s;

        pix_dark_d = ret_s.valid ? (px_dark_s & ~ret_s.last_chan) : pix_dark_q;
        found_d    = found_q | upd_s;
        fin_d      = fin_q | (ret_s.valid & ret_s.last_all);
        run_x0_d   = (upd_s && (!found_q || ret_s.x < run_x0_q)) ? ret_s.x : run_x0_q;
        run_x1_d   = (upd_s && (!found_q || ret_s.x > run_x1_q)) ? ret_s.x : run_x1_q;
        run_y0_d   = (upd_s && (!found_q || ret_s.y < run_y0_q)) ? ret_s.y : run_y0_q;
        run_y1_d   = (upd_s && (!found_q || ret_s.y > run_y1_q)) ? ret_s.y : run_y1_q;
`ifdef BBOX_PIXEL_COUNT_EN
        run_cnt_d  = upd_s ? run_cnt_q + 32'd1 : run_cnt_q;
        cnt_d      = cnt_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    rd_en_d    = 1'b1;
                    addr_d     = base_addr + FIRST_OFF;
                    x_d        = 16'd0;
                    y_d        = 16'd0;
                    c_d        = 2'd0;
                    thr_d      = threshold;
                    pix_dark_d = 1'b0;
                    found_d    = 1'b0;
                    fin_d      = 1'b0;
                    run_x0_d   = 16'd0;
                    run_x1_d   = 16'd0;
                    run_y0_d   = 16'd0;
                    run_y1_d   = 16'd0;
`ifdef BBOX_PIXEL_COUNT_EN
                    run_cnt_d  = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_ISSUE: begin
                if (last_issue_s) begin
                    rd_en_d = 1'b0;
                    state_d = S_DRAIN;
                end else if (c_q != C_LAST) begin
                    c_d    = c_q + 2'd1;
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else if (x_q != X_LAST) begin
                    c_d    = 2'd0;
                    x_d    = x_q + 16'd1;
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    c_d    = 2'd0;
                    x_d    = 16'd0;
                    y_d    = y_q + 16'd1;
                    addr_d = addr_q - ROW_BACK;
                end
            end
            S_DRAIN: begin
                if (fin_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                    empty_d = ~found_q;
                    x_min_d = found_q ? run_x0_q : 16'd0;
                    x_max_d = found_q ? run_x1_q : 16'd0;
                    y_min_d = found_q ? run_y0_q : 16'd0;
                    y_max_d = found_q ? run_y1_q : 16'd0;
`ifdef BBOX_PIXEL_COUNT_EN
                    cnt_d   = found_q ? run_cnt_q : 32'd0;
`endif
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, outputs and the tag delay line; rst discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            empty_q    <= 1'b0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            c_q        <= 2'd0;
            thr_q      <= 8'd0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            pix_dark_q <= 1'b0;
            found_q    <= 1'b0;
            fin_q      <= 1'b0;
            run_x0_q   <= 16'd0;
            run_x1_q   <= 16'd0;
            run_y0_q   <= 16'd0;
            run_y1_q   <= 16'd0;
            x_min_q    <= 16'd0;
            x_max_q    <= 16'd0;
            y_min_q    <= 16'd0;
            y_max_q    <= 16'd0;
`ifdef BBOX_PIXEL_COUNT_EN
            run_cnt_q  <= 32'd0;
            cnt_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            empty_q    <= empty_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
            thr_q      <= thr_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            pix_dark_q <= pix_dark_d;
            found_q    <= found_d;
            fin_q      <= fin_d;
            run_x0_q   <= run_x0_d;
            run_x1_q   <= run_x1_d;
            run_y0_q   <= run_y0_d;
            run_y1_q   <= run_y1_d;
            x_min_q    <= x_min_d;
            x_max_q    <= x_max_d;
            y_min_q    <= y_min_d;
            y_max_q    <= y_max_d;
`ifdef BBOX_PIXEL_COUNT_EN
            run_cnt_q  <= run_cnt_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign addr  = addr_q;
    assign rd_en = rd_en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign empty = empty_q;
    assign xMin  = x_min_q;
    assign xMax  = x_max_q;
    assign yMin  = y_min_q;
    assign yMax  = y_max_q;
`ifdef BBOX_PIXEL_COUNT_EN
    assign pixel_count = cnt_q;
`endif

endmodule

// File: tb/tb_bbox_scan.sv
// Self-checking bench for bbox_scan: two geometries (4x4x3 unpadded, 5x3x3 padded)
// driven from a vector table, with a scoreboard of expected results per scan.
module tb_bbox_scan;
    localparam int AW = 4, AH = 4, AC = 3, AL = 2;
    localparam int BW = 5, BH = 3, BC = 3, BL = 3;

    typedef struct {
        logic        e;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] y0;
        logic [15:0] y1;
        int          cnt;
    } res_t;

    typedef struct {
        int         cfg;
        logic [7:0] thr;
        int         nd;
        int         px0, py0, pc0;
        logic [7:0] pv0;
        int         px1, py1, pc1;
        logic [7:0] pv1;
        res_t       exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sel;
    logic [31:0] base;
    logic [7:0]  thr;
    logic        start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic [31:0] addr_a, addr_b, addr_m;
    logic        rd_en_a, rd_en_b, rd_en_m;
    logic [7:0]  rddata_a, rddata_b;
    logic        busy_a, busy_b, busy_m, done_a, done_b, done_m, empty_a, empty_b, empty_m;
    logic [15:0] xmin_a, xmax_a, ymin_a, ymax_a, xmin_b, xmax_b, ymin_b, ymax_b;
    logic [15:0] xmin_m, xmax_m, ymin_m, ymax_m;
`ifdef BBOX_PIXEL_COUNT_EN
    logic [31:0] pc_a, pc_b, pc_m;
    assign pc_m = sel ? pc_b : pc_a;
`endif

    assign addr_m  = sel ? addr_b  : addr_a;
    assign rd_en_m = sel ? rd_en_b : rd_en_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign done_m  = sel ? done_b  : done_a;
    assign empty_m = sel ? empty_b : empty_a;
    assign xmin_m  = sel ? xmin_b  : xmin_a;
    assign xmax_m  = sel ? xmax_b  : xmax_a;
    assign ymin_m  = sel ? ymin_b  : ymin_a;
    assign ymax_m  = sel ? ymax_b  : ymax_a;

    bbox_scan #(.WIDTH(AW), .HEIGHT(AH), .CHANNELS(AC), .ADDR_W(32), .RD_LATENCY(AL)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base), .threshold(thr),
        .addr(addr_a), .rd_en(rd_en_a), .rddata(rddata_a), .busy(busy_a), .done(done_a),
        .empty(empty_a), .xMin(xmin_a), .xMax(xmax_a), .yMin(ymin_a), .yMax(ymax_a)
`ifdef BBOX_PIXEL_COUNT_EN
        , .pixel_count(pc_a)
`endif
    );

    bbox_scan #(.WIDTH(BW), .HEIGHT(BH), .CHANNELS(BC), .ADDR_W(32), .RD_LATENCY(BL)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base), .threshold(thr),
        .addr(addr_b), .rd_en(rd_en_b), .rddata(rddata_b), .busy(busy_b), .done(done_b),
        .empty(empty_b), .xMin(xmin_b), .xMax(xmax_b), .yMin(ymin_b), .yMax(ymax_b)
`ifdef BBOX_PIXEL_COUNT_EN
        , .pixel_count(pc_b)
`endif
    );

    // Byte memory with a fixed read latency per DUT; padding bytes hold 0 (dark).
    logic [7:0] mem [0:1023];
    logic [7:0] line_a [AL];
    logic [7:0] line_b [BL];
    always @(posedge clk) begin
        line_a[0] <= rd_en_a ? mem[addr_a[9:0]] : 8'h00;
        for (int i = 1; i < AL; i++) line_a[i] <= line_a[i-1];
        line_b[0] <= rd_en_b ? mem[addr_b[9:0]] : 8'h00;
        for (int i = 1; i < BL; i++) line_b[i] <= line_b[i-1];
    end
    assign rddata_a = line_a[AL-1];
    assign rddata_b = line_b[BL-1];

    int W, H, C, L, S, N;
    int n_cmp, n_err;
    res_t prev [2];
    res_t sb_q [$];
    vec_t tbl [8];

    // Address monitor: each read in a burst is checked against the direct address formula.
    int   run_len;
    int   addr_err;
    logic rd_prev;
    initial begin
        run_len  = 0;
        addr_err = 0;
        rd_prev  = 1'b0;
    end
    always @(posedge clk) begin : mon
        int k;
        int ex;
        rd_prev <= rd_en_m;
        if (rd_en_m) begin
            k  = rd_prev ? run_len : 0;
            ex = (H - 1 - k / (C * W)) * S + ((k / C) % W) * C + (k % C);
            if (addr_m != base + 32'(ex)) addr_err <= addr_err + 1;
            run_len <= k + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int cfg, int t, int nd, int x0, int y0, int c0, int v0,
                                int x1, int y1, int c1, int v1,
                                int e, int ex0, int ex1, int ey0, int ey1, int ecnt);
        vec_t v;
        v.cfg = cfg; v.thr = 8'(t); v.nd = nd;
        v.px0 = x0; v.py0 = y0; v.pc0 = c0; v.pv0 = 8'(v0);
        v.px1 = x1; v.py1 = y1; v.pc1 = c1; v.pv1 = 8'(v1);
        v.exp.e = 1'(e); v.exp.x0 = 16'(ex0); v.exp.x1 = 16'(ex1);
        v.exp.y0 = 16'(ey0); v.exp.y1 = 16'(ey1); v.exp.cnt = ecnt;
        return v;
    endfunction

    task automatic set_cfg(input int cfg);
        sel  = cfg[0];
        W    = sel ? BW : AW;
        H    = sel ? BH : AH;
        C    = sel ? BC : AC;
        L    = sel ? BL : AL;
        S    = ((W * C + 3) / 4) * 4;
        N    = W * H * C;
        base = sel ? 32'h0000_0200 : 32'h0000_0040;
    endtask

    function automatic int pa(int x, int y, int c);
        return int'(base[9:0]) + (H - 1 - y) * S + x * C + c;
    endfunction

    task automatic load_image(input vec_t v);
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < C; c++) mem[pa(x, y, c)] = 8'hFF;
        if (v.nd > 0) mem[pa(v.px0, v.py0, v.pc0)] = v.pv0;
        if (v.nd > 1) mem[pa(v.px1, v.py1, v.pc1)] = v.pv1;
        thr = v.thr;
    endtask

    // One scan: start (or keep start held), check timing, then compare against the scoreboard.
    task automatic scan(input res_t e, input bit hold, input int abort_at);
        int   cyc;
        int   err0;
        res_t got;
        if (abort_at == 0) sb_q.push_back(e);
        err0 = addr_err;
        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk("first_addr", addr_m, base + 32'((H - 1) * S));
        chk("busy_at_start", busy_m, 1);
        chk("done_at_start", done_m, 0);
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == abort_at) return;
            if (cyc == 5) begin
                chk("hold_xmin", xmin_m, prev[sel].x0);
                chk("hold_empty", empty_m, prev[sel].e);
            end
            if (done_m) break;
        end
        chk("done_latency", cyc, N + L + 1);
        chk("busy_at_done", busy_m, 0);
        chk("rd_en_len", run_len, N);
        chk("addr_seq_err", addr_err - err0, 0);
        got = sb_q.pop_front();
        chk("empty", empty_m, got.e);
        chk("xMin", xmin_m, got.x0);
        chk("xMax", xmax_m, got.x1);
        chk("yMin", ymin_m, got.y0);
        chk("yMax", ymax_m, got.y1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("pixel_count", pc_m, got.cnt);
`endif
        prev[sel] = got;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_rd_en", rd_en_m, 0);
        chk("rst_addr", addr_m, 0);
        chk("rst_empty", empty_m, 0);
        chk("rst_xMin", xmin_m, 0);
        chk("rst_xMax", xmax_m, 0);
        chk("rst_yMin", ymin_m, 0);
        chk("rst_yMax", ymax_m, 0);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("rst_pixel_count", pc_m, 0);
`endif
    endtask

    initial begin
        res_t zero;
        n_cmp = 0; n_err = 0;
        zero  = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0};
        prev[0] = zero; prev[1] = zero;
        start = 1'b0; thr = 8'd0; rst = 1'b0;
        set_cfg(0);

        //           cfg thr nd  x0 y0 c0 v0   x1 y1 c1 v1  e  xMin xMax yMin yMax cnt
        tbl[0] = mk(0, 250, 0,  0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 250, 1,  2, 1, 1, 10,  0, 0, 0, 0,  0, 2, 2, 1, 1, 1);
        tbl[2] = mk(0, 128, 2,  0, 0, 0, 10,  3, 3, 2, 10, 0, 0, 3, 0, 3, 2);
        tbl[3] = mk(0,   5, 2,  0, 0, 0, 10,  3, 3, 2, 10, 1, 0, 0, 0, 0, 0);
        tbl[4] = mk(1, 250, 0,  0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[5] = mk(1,   0, 1,  2, 2, 0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[6] = mk(1, 200, 2,  4, 0, 2, 199, 1, 2, 0, 0,  0, 1, 4, 0, 2, 2);
        tbl[7] = mk(1, 199, 2,  4, 0, 2, 199, 1, 1, 1, 198, 0, 1, 1, 1, 1, 1);

        #1 rst = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_cfg(tbl[i].cfg);
            load_image(tbl[i]);
            scan(tbl[i].exp, 1'b0, 0);
        end

        // Asynchronous reset in the middle of ISSUE, then a clean rerun.
        set_cfg(1);
        load_image(tbl[6]);
        scan(tbl[6].exp, 1'b0, 10);
        #2 rst = 1'b1;
        #1 chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        prev[0] = zero; prev[1] = zero;
        repeat (2) @(negedge clk);
        scan(tbl[6].exp, 1'b0, 0);

        // start held high across a scan: accepted again in the first DONE cycle.
        set_cfg(0);
        load_image(tbl[1]);
        scan(tbl[1].exp, 1'b1, 0);
        scan(tbl[1].exp, 1'b1, 0);
        start = 1'b0;
        @(posedge clk);
        #1 chk("done_stays", done_m, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
